// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, flag bit
// positions, FSM state encoding and the iterative-unit operation select.
package alu_pkg;

    localparam logic [3:0] MODE_ADD = 4'd0;
    localparam logic [3:0] MODE_SUB = 4'd1;
    localparam logic [3:0] MODE_SHR = 4'd2;
    localparam logic [3:0] MODE_SHL = 4'd3;
    localparam logic [3:0] MODE_AND = 4'd4;
    localparam logic [3:0] MODE_OR  = 4'd5;
    localparam logic [3:0] MODE_NOT = 4'd6;
    localparam logic [3:0] MODE_XOR = 4'd7;
    localparam logic [3:0] MODE_ADC = 4'd8;
    localparam logic [3:0] MODE_SBB = 4'd9;
    localparam logic [3:0] MODE_MUL = 4'd11;
    localparam logic [3:0] MODE_SAR = 4'd12;

    localparam int FLAG_Z   = 0;
    localparam int FLAG_N   = 1;
    localparam int FLAG_C   = 2;
    localparam int FLAG_V   = 3;
    localparam int FLAG_ERR = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        IT_SHR = 2'd0,
        IT_SHL = 2'd1,
        IT_SAR = 2'd2,
        IT_MUL = 2'd3
    } iter_op_t;

    // Assemble the 5-bit flag word from its individual bits.
    function automatic logic [4:0] pack_flags(input logic err, input logic v,
                                              input logic c, input logic n,
                                              input logic z);
        logic [4:0] f;
        f           = '0;
        f[FLAG_ERR] = err;
        f[FLAG_V]   = v;
        f[FLAG_C]   = c;
        f[FLAG_N]   = n;
        f[FLAG_Z]   = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative datapath for shifts (one bit per cycle) and unsigned multiply
// (shift-add, one multiplier bit per cycle). Loads on start, then steps
// every cycle; finish is high during the final step, with result/carry
// showing that step's outcome so the caller can register them on that edge.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  iter_op_t         op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             finish,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int SHAMT_W = $clog2(WIDTH);
    // One extra bit so the counter can hold WIDTH for multiply.
    localparam int CNT_W   = SHAMT_W + 1;

    iter_op_t           op_q;
    logic               busy;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   sreg;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;

    logic [WIDTH-1:0]   step_val;
    logic [WIDTH-1:0]   step_acc;
    logic               step_c;
    logic [WIDTH:0]     sum;

    // One iteration step: next shift-register / accumulator value and carry.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        sum      = '0;
        step_val = sreg;
        step_acc = acc;
        step_c   = 1'b0;
        case (op_q)
            IT_SHL: begin
                step_val = {sreg[WIDTH-2:0], 1'b0};
                step_c   = sreg[WIDTH-1];
            end
            IT_SHR: begin
                step_val = {1'b0, sreg[WIDTH-1:1]};
                step_c   = sreg[0];
            end
            IT_SAR: begin
                step_val = {sreg[WIDTH-1], sreg[WIDTH-1:1]};
                step_c   = sreg[0];
            end
            IT_MUL: begin
                // {acc, sreg} is the running product; add the multiplicand
                // when the current multiplier bit is set, then shift right.
                sum      = {1'b0, acc} + (sreg[0] ? {1'b0, mcand} : '0);
                step_acc = sum[WIDTH:1];
                step_val = {sum[0], sreg[WIDTH-1:1]};
                step_c   = |step_acc;
            end
            default: ;
        endcase
    end

    assign finish = busy && (cnt == CNT_W'(1));
    assign result = step_val;
    assign carry  = step_c;

    // Control: busy flag and remaining-step counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= (op == IT_MUL) ? CNT_W'(WIDTH) : {1'b0, b[SHAMT_W-1:0]};
        end else if (busy) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                busy <= 1'b0;
            end
        end
    end

    // Datapath registers: load operands on start, advance one step per busy cycle.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; start always loads them before busy lets them be used.
        if (start) begin
            op_q  <= op;
            acc   <= '0;
            mcand <= a;
            sreg  <= (op == IT_MUL) ? b : a;
        end else if (busy) begin
            sreg <= step_val;
            acc  <= step_acc;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU between register-file read and writeback. Valid/ready on
// both sides; single-cycle ops complete straight from IDLE, shifts and
// multiply run in alu_iter_unit. Result and flags are held until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [4:0]       flags
);

    state_t           state;
    state_t           next_state;
    logic [3:0]       mode_q;
    logic             accept;
    logic             start;

    logic             is_shift;
    logic             amt_zero;
    logic             amt_big;
    logic             needs_iter;
    iter_op_t         iter_op;

    logic             cin;
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH-1:0] fast_res;
    logic             fast_c;
    logic             fast_v;
    logic             fast_err;
    logic [4:0]       fast_flags;

    logic             iter_finish;
    logic [WIDTH-1:0] iter_result;
    logic             iter_carry;
    logic [4:0]       iter_flags;

    assign is_shift   = (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_SAR);
    assign amt_zero   = (in2 == '0);
    assign amt_big    = (in2 >= WIDTH'(WIDTH));
    assign needs_iter = (mode == MODE_MUL) || (is_shift && !amt_zero && !amt_big);
    assign start      = accept && needs_iter;

    // Map the operation code onto the iterative unit's operation select.
    always_comb begin
        iter_op = IT_SHR;
        case (mode)
            MODE_SHL: iter_op = IT_SHL;
            MODE_SAR: iter_op = IT_SAR;
            MODE_MUL: iter_op = IT_MUL;
            default:  iter_op = IT_SHR;
        endcase
    end

    // Single-cycle results, including degenerate shifts and illegal modes.
    always_comb begin
        cin      = ((mode == MODE_ADC) || (mode == MODE_SBB)) ? flags[FLAG_C] : 1'b0;
        add_w    = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};
        sub_w    = {1'b0, in1} - {1'b0, in2} - {{WIDTH{1'b0}}, cin};
        fast_res = '0;
        fast_c   = 1'b0;
        fast_v   = 1'b0;
        fast_err = 1'b0;
        case (mode)
            MODE_ADD, MODE_ADC: begin
                fast_res = add_w[WIDTH-1:0];
                fast_c   = add_w[WIDTH];
                fast_v   = (in1[WIDTH-1] == in2[WIDTH-1]) && (add_w[WIDTH-1] != in1[WIDTH-1]);
            end
            MODE_SUB, MODE_SBB: begin
                // Bit WIDTH of the widened difference is the borrow.
                fast_res = sub_w[WIDTH-1:0];
                fast_c   = sub_w[WIDTH];
                fast_v   = (in1[WIDTH-1] != in2[WIDTH-1]) && (sub_w[WIDTH-1] != in1[WIDTH-1]);
            end
            MODE_SHR, MODE_SHL: fast_res = amt_zero ? in1 : '0;
            MODE_SAR:           fast_res = amt_zero ? in1 : {WIDTH{in1[WIDTH-1]}};
            MODE_AND:           fast_res = in1 & in2;
            MODE_OR:            fast_res = in1 | in2;
            MODE_XOR:           fast_res = in1 ^ in2;
            MODE_NOT:           fast_res = ~in1;
            MODE_MUL:           fast_res = '0;
            default:            fast_err = 1'b1;
        endcase
    end

    assign fast_flags = pack_flags(fast_err, fast_v, fast_c, fast_res[WIDTH-1], fast_res == '0);
    assign iter_flags = pack_flags(1'b0, (mode_q == MODE_MUL) && iter_carry, iter_carry,
                                   iter_result[WIDTH-1], iter_result == '0);

    alu_iter_unit #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (iter_op),
        .a      (in1),
        .b      (in2),
        .finish (iter_finish),
        .result (iter_result),
        .carry  (iter_carry)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = needs_iter ? ST_EXEC : ST_DONE;
                end
            end
            ST_EXEC: begin
                if (iter_finish) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Result and flag registers, written only when an operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out    <= '0;
            flags  <= '0;
            mode_q <= '0;
        end else if (accept) begin
            mode_q <= mode;
            if (!needs_iter) begin
                out   <= fast_res;
                flags <= fast_flags;
            end
        end else if ((state == ST_EXEC) && iter_finish) begin
            out   <= iter_result;
            flags <= iter_flags;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16). Expected results are pushed to
// a scoreboard queue when an operation is driven and popped when out_valid
// rises; each scenario task does its own comparisons.
module tb_alu_seq;

    localparam int W = 16;
    localparam longint MAXU = (64'd1 << W) - 1;
    localparam longint MAXS = (64'd1 << (W - 1)) - 1;
    localparam longint MINS = -(64'd1 << (W - 1));

    typedef struct {
        logic [W-1:0] out;
        logic [4:0]   flags;
        int           lat;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [3:0]   mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic [4:0]   flags;

    exp_t scoreboard[$];
    int   tests_run;
    int   tests_failed;
    logic exp_c;

    alu_seq #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model written directly from the operation definitions.
    function automatic void model(input logic [3:0] m, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input logic cin,
                                  output logic [W-1:0] r, output logic [4:0] f,
                                  output int lat);
        longint ua, ub, sa, sbv, ci, t, st;
        int     sh;
        logic   c, v, e;
        ua  = longint'(a);
        ub  = longint'(b);
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ci  = ((m == 4'd8) || (m == 4'd9)) ? longint'(cin) : 0;
        sh  = (b >= W) ? W : int'(b);
        c = 1'b0; v = 1'b0; e = 1'b0; r = '0; lat = 1;
        case (m)
            4'd0, 4'd8: begin
                t = ua + ub + ci; r = W'(t); c = (t > MAXU);
                st = sa + sbv + ci; v = (st > MAXS) || (st < MINS);
            end
            4'd1, 4'd9: begin
                t = ua - ub - ci; r = W'(t); c = (ua < ub + ci);
                st = sa - sbv - ci; v = (st > MAXS) || (st < MINS);
            end
            4'd2: begin
                if (sh == 0) r = a;
                else if (sh >= W) r = '0;
                else begin r = a >> sh; c = a[sh-1]; lat = sh + 1; end
            end
            4'd3: begin
                if (sh == 0) r = a;
                else if (sh >= W) r = '0;
                else begin r = a << sh; c = a[W-sh]; lat = sh + 1; end
            end
            4'd12: begin
                if (sh == 0) r = a;
                else if (sh >= W) r = {W{a[W-1]}};
                else begin r = W'($signed(a) >>> sh); c = a[sh-1]; lat = sh + 1; end
            end
            4'd4: r = a & b;
            4'd5: r = a | b;
            4'd6: r = ~a;
            4'd7: r = a ^ b;
            4'd11: begin
                t = ua * ub; r = W'(t); c = ((t >> W) != 0); v = c; lat = W + 1;
            end
            default: e = 1'b1;
        endcase
        f = {e, v, c, r[W-1], (r == '0)};
    endfunction

    // Drive one operation, check latency/busy/result/flags, optionally hold
    // the result with out_ready low, then consume it.
    task automatic run_op(input string name, input logic [3:0] m,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_out, input logic [4:0] e_flags,
                          input int e_lat, input int hold);
        exp_t         e;
        int           lat;
        int           guard;
        bit           ready_bad;
        bit           stable;
        logic [W-1:0] o_snap;
        logic [4:0]   f_snap;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s idle_wait: in_ready=%b required 1", name, in_ready);
        end
        in_valid = 1'b1; in1 = a; in2 = b; mode = m;
        scoreboard.push_back('{out: e_out, flags: e_flags, lat: e_lat, name: name});
        @(negedge clk);
        in_valid  = 1'b0;
        lat       = 1;
        ready_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) ready_bad = 1'b1;
            in1 = W'($urandom); in2 = W'($urandom); mode = 4'($urandom);
            @(negedge clk);
            lat++;
        end
        e = scoreboard.pop_front();
        exp_c = e.flags[2];
        tests_run++;
        if (lat !== e.lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d required %0d", e.name, lat, e.lat);
        end
        tests_run++;
        if (ready_bad || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_ready: in_ready seen high while busy/done (now %b) required 0", e.name, in_ready);
        end
        tests_run++;
        if (out !== e.out) begin
            tests_failed++;
            $display("FAIL %s out: got %h required %h", e.name, out, e.out);
        end
        tests_run++;
        if (flags !== e.flags) begin
            tests_failed++;
            $display("FAIL %s flags: got %b required %b", e.name, flags, e.flags);
        end
        o_snap = out; f_snap = flags; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            // Offer a new op while DONE; it must be ignored.
            in_valid = 1'b1; in1 = W'($urandom); in2 = W'($urandom); mode = 4'($urandom);
            @(negedge clk);
            if (!out_valid || out !== o_snap || flags !== f_snap) stable = 1'b0;
        end
        if (hold > 0) begin
            tests_run++;
            if (!stable) begin
                tests_failed++;
                $display("FAIL %s hold: out=%h flags=%b valid=%b required %h %b 1", e.name, out, flags, out_valid, o_snap, f_snap);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s to_idle: out_valid=%b in_ready=%b required 0 1", e.name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        tests_run++;
        if (out !== '0 || flags !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: out=%h flags=%b required 0000 00000", out, flags);
        end
        exp_c = 1'b0;
    endtask

    task automatic test_add_sub_adc();
        run_op("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 5'b00101, 1, 0);
        run_op("sub_ovf",  4'd1, 16'h7FFF, 16'hFFFF, 16'h8000, 5'b01110, 1, 0);
        run_op("adc_cin",  4'd8, 16'h0001, 16'h0001, 16'h0003, 5'b00000, 1, 0);
        run_op("sub_brw",  4'd1, 16'h0000, 16'h0001, 16'hFFFF, 5'b00110, 1, 0);
        run_op("sbb_cin",  4'd9, 16'h0005, 16'h0003, 16'h0001, 5'b00000, 1, 0);
    endtask

    task automatic test_shift();
        run_op("shl_3",    4'd3,  16'h8001, 16'd3,  16'h0008, 5'b00000, 4, 0);
        run_op("sar_big",  4'd12, 16'h8000, 16'd20, 16'hFFFF, 5'b00010, 1, 0);
        run_op("shr_1",    4'd2,  16'h0003, 16'd1,  16'h0001, 5'b00100, 2, 0);
        run_op("shl_0",    4'd3,  16'h1234, 16'd0,  16'h1234, 5'b00000, 1, 0);
        run_op("shr_15",   4'd2,  16'hFFFF, 16'd15, 16'h0001, 5'b00100, 16, 0);
        run_op("shl_16",   4'd3,  16'hFFFF, 16'd16, 16'h0000, 5'b00001, 1, 0);
    endtask

    task automatic test_mul_backpressure();
        run_op("mul_ovf",  4'd11, 16'h0100, 16'h0100, 16'h0000, 5'b01101, 17, 5);
        run_op("mul_small", 4'd11, 16'h00FF, 16'h0003, 16'h02FD, 5'b00000, 17, 0);
    endtask

    task automatic test_back_to_back();
        logic [3:0]   mlist [12];
        logic [3:0]   m;
        logic [W-1:0] a, b, r;
        logic [4:0]   f;
        int           lat;
        mlist = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};
        for (int i = 0; i < 12; i++) begin
            m = mlist[i];
            a = W'($urandom);
            b = ((m == 4'd2) || (m == 4'd3) || (m == 4'd12)) ? W'($urandom_range(0, 20)) : W'($urandom);
            model(m, a, b, exp_c, r, f, lat);
            run_op($sformatf("rand%0d_m%0d", i, m), m, a, b, r, f, lat, 0);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        run_op("not_pre", 4'd6, 16'h00FF, 16'h0000, 16'hFF00, 5'b00010, 1, 0);
        in_valid = 1'b1; mode = 4'd11; in1 = 16'h1234; in2 = 16'h5678;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_hs: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        tests_run++;
        if (out !== '0 || flags !== 5'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_regs: out=%h flags=%b required 0000 00000", out, flags);
        end
        exp_c = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL rst_mid_ghost: out_valid rose after reset, required none");
        end
    endtask

    task automatic test_illegal();
        run_op("illegal14", 4'd14, 16'hABCD, 16'h1234, 16'h0000, 5'b10001, 1, 0);
        run_op("illegal10", 4'd10, 16'h0001, 16'h0001, 16'h0000, 5'b10001, 1, 0);
    endtask

    // Hard stop in case any wait escapes its bound.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0; tests_failed = 0; exp_c = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in1 = '0; in2 = '0; mode = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_add_sub_adc();
        test_shift();
        test_mul_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        test_illegal();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
